sideways_memory_controller: RTL and testbench
=============================================

// Module: sideways_memory_controller
// PURPOSE
//  Time-sliced memory subsystem for the BBC micro core: main RAM, the OS ROM and
//  a parametrised set of paged "sideways" banks at 8000-BFFF, selected by the ROMSEL latch.
//  Any bank can be configured as writeable sideways RAM.
//  Serves MOS6502 reads and writes, and CRTC/video fetches, in alternate RAM_en slots.
//  Adds bank-presence checking and a sticky write-protect violation flag.
// PARAMETERS
//  BANKS          4        number of populated sideways banks (1..16)
//  BANK_W         4        width of the ROMSEL bank field
//  RAM_BANK_MASK  16'h0000 bit n=1: bank n is writeable sideways RAM
//  MAIN_AW        15       main RAM address width (32 KiB)
//  RESET_BANK     0        bank selected after reset
// PORTS
//  PIXELCLK     in   1        system clock; all state on rising edge
//  nRESET       in   1        asynchronous active-low reset
//  RAM_en       in   1        memory slot strobe, one PIXELCLK wide
//  V_TURN       in   1        1: video slot (CPU write allowed); 0: CPU read slot
//  PHI_2        in   1        6502 phase 2
//  PROC_en      in   1        CPU clock enable
//  nROMSEL      in   1        ROMSEL latch chip select, active low
//  RnW          in   1        CPU read/not-write
//  cpu_addr     in   16       CPU address bus
//  cpu_wdata    in   8        CPU write data
//  cpu_rdata    out  8        registered CPU read data
//  cpu_rvalid   out  1        1-cycle pulse when cpu_rdata is updated
//  vid_addr     in   MAIN_AW  corrected framestore address
//  vid_data     out  8        registered video fetch data
//  vid_valid    out  1        1-cycle pulse when vid_data is updated
//  bank_sel     out  BANK_W   current ROMSEL value
//  wp_violation out  1        sticky: write attempted to a ROM or absent bank
// BEHAVIOUR
//  Reset (async, nRESET=0):
//   - bank_sel=RESET_BANK; cpu_rdata=vid_data=8'h00; cpu_rvalid=vid_valid=wp_violation=0.
//   - Memory contents are untouched.
//   - A slot in flight at reset is discarded; no write occurs.
//  Address map:
//   - 0000-7FFF main RAM; 8000-BFFF sideways[bank_sel]; C000-FFFF OS ROM.
//   - FE00-FEFF is the I/O window: no read capture and no write. cpu_rvalid stays 0 and cpu_rdata holds.
//  ROMSEL latch:
//   - Write: PROC_en & ~nROMSEL & ~RnW loads bank_sel <= cpu_wdata[BANK_W-1:0].
//   - The new bank takes effect from the next slot.
//   - A sideways access in the same edge uses the old bank.
//  CPU read slot (RAM_en & ~V_TURN & ~PHI_2, address outside I/O window):
//   - cpu_rdata loads on that edge; cpu_rvalid=1 for exactly one cycle. Latency 1 PIXELCLK.
//   - Sideways read with bank_sel >= BANKS returns 8'hFF (empty socket).
//  Video slot (RAM_en & V_TURN):
//   - vid_data <= main_ram[vid_addr]; vid_valid pulses for one cycle.
//   - In the same slot, if PHI_2 & ~RnW, the CPU write is performed:
//     - cpu_addr[15]=0: write main_ram[cpu_addr[MAIN_AW-1:0]].
//     - 8000-BFFF with bank_sel<BANKS and RAM_BANK_MASK[bank_sel]=1: write the sideways bank.
//     - Any other sideways write, or any OS ROM write: no write; wp_violation<=1 (sticky until reset).
//   - Same-address video read and CPU write in one slot: video gets OLD data (read-before-write).
//  Arithmetic and width:
//   - Bank index is compared against BANKS at full BANK_W width; no wrap-around or aliasing.
//   - Video addresses wrap modulo 2^MAIN_AW.
//  No state machine beyond the slot decode. At most one capture per slot; the valid pulses never overlap a reset.
// TESTING
//  1. Reset with RESET_BANK=0 -> bank_sel=0, all outputs 0. Read 8000 -> cpu_rdata=bank0[0000], cpu_rvalid pulse 1 cycle.
//  2. ROMSEL write 8'h03 in the same edge as a sideways read -> that read returns bank0 data; the next read returns bank3 data.
//  3. ROMSEL=5 with BANKS=4, read 9000 -> cpu_rdata=8'hFF, wp_violation stays 0.
//  4. RAM_BANK_MASK=16'h0002, bank 1, write 8'hA5 to 8010, read back -> 8'hA5.
//     Bank 0 write -> data unchanged, wp_violation=1 until nRESET.
//  5. Video slot: vid_addr=0x0100 with CPU write 8'h3C to 0x0100 -> vid_data=old value.
//     Next video fetch -> 8'h3C.
//  6. CPU read of FE40 -> no cpu_rvalid, cpu_rdata unchanged.
//     Assert nRESET mid-slot -> outputs 0 immediately, no write lands.

Source files
------------

// File: rtl/sideways_memory_controller.sv
// BBC micro memory subsystem with time-sliced slots: main RAM, OS ROM and paged sideways banks (ROMSEL).
// CPU reads and video fetches capture one PIXELCLK after their slot; there is no backpressure and the slot strobe is the only pacing.
module sideways_memory_controller #(
    parameter int                BANKS         = 4,
    parameter int                BANK_W        = 4,
    parameter logic [15:0]       RAM_BANK_MASK = 16'h0000,
    parameter int                MAIN_AW       = 15,
    parameter logic [BANK_W-1:0] RESET_BANK    = '0
) (
    input  logic               PIXELCLK,
    input  logic               nRESET,
    input  logic               RAM_en,
    input  logic               V_TURN,
    input  logic               PHI_2,
    input  logic               PROC_en,
    input  logic               nROMSEL,
    input  logic               RnW,
    input  logic [15:0]        cpu_addr,
    input  logic [7:0]         cpu_wdata,
    output logic [7:0]         cpu_rdata,
    output logic               cpu_rvalid,
    input  logic [MAIN_AW-1:0] vid_addr,
    output logic [7:0]         vid_data,
    output logic               vid_valid,
    output logic [BANK_W-1:0]  bank_sel,
    output logic               wp_violation
);

    localparam int              PAGE       = 16384;
    localparam int              ROM_AW     = $clog2((BANKS + 1) * PAGE);
    localparam logic [BANK_W:0] BANK_LIMIT = (BANK_W + 1)'(BANKS);

    // Sideways banks occupy pages 0..BANKS-1 of rom_mem; the OS ROM is page BANKS.
    logic [7:0] main_ram [0:(1 << MAIN_AW) - 1];
    logic [7:0] rom_mem  [0:(BANKS + 1) * PAGE - 1];

    logic              io_win;
    logic              is_main;
    logic              is_sw;
    logic              bank_ok;
    logic              sw_wr_ok;
    logic              rd_slot;
    logic              vid_slot;
    logic              cpu_wr;
    logic              romsel_wr;
    logic [BANK_W:0]   page;
    logic [ROM_AW-1:0] rom_idx;
    logic [7:0]        rd_byte;

    always_comb begin
        io_win    = (cpu_addr[15:8] == 8'hFE);
        is_main   = ~cpu_addr[15];
        is_sw     = (cpu_addr[15:14] == 2'b10);
        bank_ok   = ({1'b0, bank_sel} < BANK_LIMIT);
        sw_wr_ok  = bank_ok && RAM_BANK_MASK[bank_sel];
        page      = is_sw ? {1'b0, bank_sel} : BANK_LIMIT;
        rom_idx   = ROM_AW'({page, cpu_addr[13:0]});
        rd_slot   = RAM_en & ~V_TURN & ~PHI_2 & ~io_win;
        vid_slot  = RAM_en & V_TURN;
        cpu_wr    = vid_slot & PHI_2 & ~RnW & ~io_win;
        romsel_wr = PROC_en & ~nROMSEL & ~RnW;
        rd_byte   = 8'hFF;
        if (is_main) begin
            rd_byte = main_ram[cpu_addr[MAIN_AW-1:0]];
        end else if (!is_sw || bank_ok) begin
            rd_byte = rom_mem[rom_idx];
        end
    end

    // Memory writes sit in the reset branch's else so a slot caught by reset never lands.
    always_ff @(posedge PIXELCLK or negedge nRESET) begin
        if (!nRESET) begin
            bank_sel     <= RESET_BANK;
            cpu_rdata    <= 8'h00;
            cpu_rvalid   <= 1'b0;
            vid_data     <= 8'h00;
            vid_valid    <= 1'b0;
            wp_violation <= 1'b0;
        end else begin
            cpu_rvalid <= rd_slot;
            vid_valid  <= vid_slot;
            if (rd_slot) begin
                cpu_rdata <= rd_byte;
            end
            if (vid_slot) begin
                vid_data <= main_ram[vid_addr];
            end
            if (cpu_wr) begin
                if (is_main) begin
                    main_ram[cpu_addr[MAIN_AW-1:0]] <= cpu_wdata;
                end else if (is_sw && sw_wr_ok) begin
                    rom_mem[rom_idx] <= cpu_wdata;
                end else begin
                    wp_violation <= 1'b1;
                end
            end
            if (romsel_wr) begin
                bank_sel <= cpu_wdata[BANK_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_sideways_memory_controller.sv
// Bench for sideways_memory_controller: directed scenarios then randomized slots against a byte-level memory model.
module tb_sideways_memory_controller;

    localparam int          BANKS   = 4;
    localparam int          BANK_W  = 4;
    localparam logic [15:0] MASK    = 16'h0002;
    localparam int          MAIN_AW = 15;
    localparam int          PAGE    = 16384;

    logic               PIXELCLK;
    logic               nRESET;
    logic               RAM_en;
    logic               V_TURN;
    logic               PHI_2;
    logic               PROC_en;
    logic               nROMSEL;
    logic               RnW;
    logic [15:0]        cpu_addr;
    logic [7:0]         cpu_wdata;
    logic [7:0]         cpu_rdata;
    logic               cpu_rvalid;
    logic [MAIN_AW-1:0] vid_addr;
    logic [7:0]         vid_data;
    logic               vid_valid;
    logic [BANK_W-1:0]  bank_sel;
    logic               wp_violation;

    sideways_memory_controller #(
        .BANKS(BANKS), .BANK_W(BANK_W), .RAM_BANK_MASK(MASK),
        .MAIN_AW(MAIN_AW), .RESET_BANK(4'd0)
    ) dut (
        .PIXELCLK(PIXELCLK), .nRESET(nRESET), .RAM_en(RAM_en), .V_TURN(V_TURN),
        .PHI_2(PHI_2), .PROC_en(PROC_en), .nROMSEL(nROMSEL), .RnW(RnW),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_valid(vid_valid), .bank_sel(bank_sel), .wp_violation(wp_violation)
    );

    initial PIXELCLK = 1'b0;
    always #5 PIXELCLK = ~PIXELCLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain byte arrays per memory region plus the visible output state.
    logic [7:0] m_main [0:32767];
    logic [7:0] m_sw   [0:BANKS-1][0:PAGE-1];
    logic [7:0] m_os   [0:PAGE-1];
    logic [3:0] m_bank;
    logic       m_wp;
    logic [7:0] m_rdata;
    logic [7:0] m_vdata;
    logic       m_rv;
    logic       m_vv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bank  = 4'd0;
        m_wp    = 1'b0;
        m_rdata = 8'h00;
        m_vdata = 8'h00;
        m_rv    = 1'b0;
        m_vv    = 1'b0;
    endtask

    function automatic logic [7:0] m_read(input logic [15:0] a);
        if (a < 16'h8000) return m_main[a[14:0]];
        if (a < 16'hC000) return (int'(m_bank) < BANKS) ? m_sw[int'(m_bank)][a[13:0]] : 8'hFF;
        return m_os[a[13:0]];
    endfunction

    task automatic model_edge();
        logic        io;
        logic [15:0] mask_v;
        mask_v = MASK;
        io = (cpu_addr >= 16'hFE00) && (cpu_addr <= 16'hFEFF);
        m_rv = 1'b0;
        m_vv = 1'b0;
        if (RAM_en && !V_TURN && !PHI_2 && !io) begin
            m_rdata = m_read(cpu_addr);
            m_rv    = 1'b1;
        end
        if (RAM_en && V_TURN) begin
            m_vdata = m_main[vid_addr];
            m_vv    = 1'b1;
            if (PHI_2 && !RnW && !io) begin
                if (cpu_addr < 16'h8000)
                    m_main[cpu_addr[14:0]] = cpu_wdata;
                else if (cpu_addr < 16'hC000 && int'(m_bank) < BANKS && mask_v[m_bank])
                    m_sw[int'(m_bank)][cpu_addr[13:0]] = cpu_wdata;
                else
                    m_wp = 1'b1;
            end
        end
        if (PROC_en && !nROMSEL && !RnW) m_bank = cpu_wdata[3:0];
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cpu_rdata"}, 32'(cpu_rdata), 32'(m_rdata));
        check({tag, ".cpu_rvalid"}, 32'(cpu_rvalid), 32'(m_rv));
        check({tag, ".vid_data"}, 32'(vid_data), 32'(m_vdata));
        check({tag, ".vid_valid"}, 32'(vid_valid), 32'(m_vv));
        check({tag, ".bank_sel"}, 32'(bank_sel), 32'(m_bank));
        check({tag, ".wp"}, 32'(wp_violation), 32'(m_wp));
    endtask

    task automatic apply(input string tag, input logic ram_en_i, input logic v_turn_i,
                         input logic phi2_i, input logic proc_en_i, input logic nromsel_i,
                         input logic rnw_i, input logic [15:0] a, input logic [7:0] wd,
                         input logic [14:0] va);
        @(negedge PIXELCLK);
        RAM_en = ram_en_i; V_TURN = v_turn_i; PHI_2 = phi2_i; PROC_en = proc_en_i;
        nROMSEL = nromsel_i; RnW = rnw_i; cpu_addr = a; cpu_wdata = wd; vid_addr = va;
        @(posedge PIXELCLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        apply(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00, 15'h0000);
    endtask

    task automatic cpu_read(input string tag, input logic [15:0] a);
        apply(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a, 8'h00, 15'h0000);
    endtask

    task automatic cpu_write(input string tag, input logic [15:0] a, input logic [7:0] d,
                             input logic [14:0] va);
        apply(tag, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, a, d, va);
    endtask

    task automatic romsel(input string tag, input logic [7:0] b);
        apply(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFE30, b, 15'h0000);
    endtask

    initial begin
        logic [7:0]  v;
        logic [7:0]  held;
        logic [15:0] ra;
        logic [14:0] rv;

        nRESET = 1'b0; RAM_en = 1'b0; V_TURN = 1'b0; PHI_2 = 1'b0; PROC_en = 1'b0;
        nROMSEL = 1'b1; RnW = 1'b1; cpu_addr = '0; cpu_wdata = '0; vid_addr = '0;
        model_reset();

        for (int i = 0; i < 32768; i++) begin
            v = 8'($urandom); m_main[i] = v; dut.main_ram[i] = v;
        end
        for (int b = 0; b < BANKS; b++) begin
            for (int i = 0; i < PAGE; i++) begin
                v = 8'($urandom); m_sw[b][i] = v; dut.rom_mem[b * PAGE + i] = v;
            end
        end
        for (int i = 0; i < PAGE; i++) begin
            v = 8'($urandom); m_os[i] = v; dut.rom_mem[BANKS * PAGE + i] = v;
        end
        m_sw[0][0] = 8'h11;     dut.rom_mem[0]                = 8'h11;
        m_sw[3][0] = 8'h33;     dut.rom_mem[3 * PAGE]         = 8'h33;
        m_sw[0][16'h10] = 8'h5A; dut.rom_mem[16'h10]          = 8'h5A;
        m_main[16'h100] = 8'hC3; dut.main_ram[16'h100]        = 8'hC3;
        m_main[16'h200] = 8'h18; dut.main_ram[16'h200]        = 8'h18;

        #12;
        check_all("reset");
        @(negedge PIXELCLK);
        nRESET = 1'b1;

        // Reset bank, first sideways read and one-cycle valid pulse.
        cpu_read("t1_read", 16'h8000);
        check("t1_bank0", 32'(cpu_rdata), 32'h11);
        idle("t1_idle");
        check("t1_pulse", 32'(cpu_rvalid), 32'h0);

        // ROMSEL write on the same edge as a sideways read uses the old bank.
        apply("t2_same", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h8000, 8'h03, 15'h0000);
        check("t2_oldbank", 32'(cpu_rdata), 32'h11);
        cpu_read("t2_next", 16'h8000);
        check("t2_bank3", 32'(cpu_rdata), 32'h33);

        // Absent bank reads as 0xFF and raises no violation.
        romsel("t3_sel", 8'h05);
        cpu_read("t3_read", 16'h9000);
        check("t3_empty", 32'(cpu_rdata), 32'hFF);
        check("t3_nowp", 32'(wp_violation), 32'h0);

        // Writeable bank 1 versus ROM bank 0.
        romsel("t4_sel1", 8'h01);
        cpu_write("t4_wr1", 16'h8010, 8'hA5, 15'h0000);
        cpu_read("t4_rd1", 16'h8010);
        check("t4_ram", 32'(cpu_rdata), 32'hA5);
        romsel("t4_sel0", 8'h00);
        cpu_write("t4_wr0", 16'h8010, 8'hA5, 15'h0000);
        check("t4_wp", 32'(wp_violation), 32'h1);
        cpu_read("t4_rd0", 16'h8010);
        check("t4_rom", 32'(cpu_rdata), 32'h5A);
        idle("t4_sticky");
        check("t4_sticky_wp", 32'(wp_violation), 32'h1);

        // Read-before-write on a shared video/CPU address, then video wrap at top of RAM.
        cpu_write("t5_rbw", 16'h0100, 8'h3C, 15'h0100);
        check("t5_old", 32'(vid_data), 32'hC3);
        apply("t5_next", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00, 15'h0100);
        check("t5_new", 32'(vid_data), 32'h3C);
        apply("t5_top", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00, 15'h7FFF);

        // I/O window: no capture.
        held = m_rdata;
        cpu_read("t6_io", 16'hFE40);
        check("t6_novalid", 32'(cpu_rvalid), 32'h0);
        check("t6_hold", 32'(cpu_rdata), 32'(held));

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0: ra = 16'h0100 + 16'($urandom_range(0, 7));
                1: ra = 16'h0200 + 16'($urandom_range(0, 7));
                2: ra = 16'h8010 + 16'($urandom_range(0, 7));
                3: ra = 16'h9000 + 16'($urandom_range(0, 7));
                4: ra = 16'hC020 + 16'($urandom_range(0, 7));
                default: ra = 16'hFE40 + 16'($urandom_range(0, 7));
            endcase
            rv = ($urandom_range(0, 3) == 0) ? 15'h7FF8 + 15'($urandom_range(0, 7))
                                             : 15'h0100 + 15'($urandom_range(0, 7));
            apply("rand", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) != 0), 1'($urandom), ra, 8'($urandom_range(0, 7)), rv);
        end

        // Reset arriving in the middle of a write slot: outputs clear at once, write is dropped.
        cpu_read("t7_pre", 16'h0200);
        @(negedge PIXELCLK);
        RAM_en = 1'b1; V_TURN = 1'b1; PHI_2 = 1'b1; RnW = 1'b0; PROC_en = 1'b0;
        nROMSEL = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'hE7; vid_addr = 15'h0200;
        #2;
        nRESET = 1'b0;
        model_reset();
        #1;
        check_all("t7_async");
        @(posedge PIXELCLK);
        #1;
        check_all("t7_held");
        @(negedge PIXELCLK);
        nRESET = 1'b1; RAM_en = 1'b0; V_TURN = 1'b0; PHI_2 = 1'b0; RnW = 1'b1;
        cpu_read("t7_after", 16'h0200);
        check("t7_nowrite", 32'(cpu_rdata), 32'h18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
